alignment_lock: RTL and testbench
=================================

Name: alignment_lock

Overview:
- Per-lane 40GBASE-R alignment marker lock state machine (IEEE 802.3-2022 82.2.12 style).
- Sits directly downstream of the per-lane alignment marker detector/BIP checker, which supplies `marker_detect` and `bip_valid`.
- Tracks marker periodicity, declares and drops per-lane marker lock, and flags marker blocks for removal ahead of lane deskew.
- Reports BIP errors on locked marker positions.

Parameters:
- AM_SPACING, 16384: valid blocks per marker period, marker block included. Minimum 4. Benches use 16.
- INVLD_LIMIT, 4: consecutive missing or incorrect markers that drop lock. Range 1..15.
- BIP_CNT_W, 16: width of the BIP error counter.

Ports:
- clk  in  1  block clock
- reset  in  1  asynchronous, active-high
- block_valid  in  1  a new 66-bit block is present this cycle
- block_lock  in  1  lane 66b block lock from the sync-header stage
- marker_detect  in  1  current block matches this lane's marker pattern; qualified by block_valid
- bip_valid  in  1  received BIP matches the computed BIP; meaningful only with marker_detect
- bip_cnt_clr  in  1  synchronous clear of bip_err_cnt
- am_lock  out  1  lane marker lock
- am_strip  out  1  one-cycle pulse: the previous valid block was a locked marker position
- bip_err  out  1  one-cycle pulse: that marker position carried a BIP mismatch
- bip_err_cnt  out  BIP_CNT_W  saturating BIP error count

Behaviour:
- Reset: clk is the only clock; reset is asynchronous, active-high.
  - State goes to LOCK_INIT.
  - blk_cnt, invld_cnt and bip_err_cnt go to 0.
  - am_lock, am_strip and bip_err go to 0.
- All outputs are registered; latency is 1 cycle from the qualifying block_valid cycle.
- blk_cnt is ceil(log2(AM_SPACING)) bits.
  - It is set to 0 on a marker-anchor block and increments on every other valid block.
  - Expected position (exp_pos) = block_valid && blk_cnt == AM_SPACING-1. exp_pos re-anchors blk_cnt to 0.
  - blk_cnt and exp_pos hold when block_valid is low.
- States:
  - LOCK_INIT: am_lock=0, invld_cnt=0. block_lock high -> FIND_1ST.
  - FIND_1ST: block_valid && marker_detect -> blk_cnt<=0, go to COUNT_1.
  - COUNT_1: marker_detect on non-exp_pos blocks is ignored.
    - exp_pos && marker_detect -> LOCKED, am_lock<=1, invld_cnt<=0.
    - exp_pos && !marker_detect -> FIND_1ST. The current block is not an anchor, so the search resumes on the next valid block.
  - LOCKED: am_lock=1. On exp_pos:
    - marker_detect -> invld_cnt<=0.
    - Otherwise invld_cnt+1. When it reaches INVLD_LIMIT -> LOCK_INIT, am_lock<=0 on the same edge.
- block_lock low in any state -> LOCK_INIT on the next edge. This has priority over every other transition.
- am_strip is pulsed for every exp_pos that ends in LOCKED:
  - the confirming second marker in COUNT_1;
  - every exp_pos in LOCKED, with or without a marker, until the limit-th miss. The limit-th miss is not stripped.
- bip_err is pulsed when am_strip fires, marker_detect is high, and bip_valid is low. A missing marker never raises bip_err.
- bip_err_cnt increments on bip_err and saturates at all-ones.
  - bip_cnt_clr has priority; clear and increment in the same cycle gives 0.
- Markers seen at non-expected positions while LOCKED are ignored. No re-anchor; lock is regained only via LOCK_INIT.

Optional Feature:
- Macro ALIGN_LOCK_BIP_CNT_EN.
  - Defined: bip_err_cnt and bip_cnt_clr behave as above.
  - Undefined: the counter is not built, bip_err_cnt is tied to 0 and bip_cnt_clr is ignored. The bip_err pulse is unaffected.

Decomposition:
- Shared package pcs_pkg holds:
  - AM_SPACING_DEFAULT = 16384;
  - typedef enum am_lock_state_t {LOCK_INIT, FIND_1ST, COUNT_1, LOCKED};
  - the 4-lane marker pattern constants, moved out of the detector.
- One natural sub-module, sat_counter, a generic saturating counter with synchronous clear. It is used for bip_err_cnt and reused by the other PCS error counters.

Test Plan (AM_SPACING=16, INVLD_LIMIT=4, block_valid constant unless stated):
- Lock acquire: block_lock=1, markers at blocks 0 and 16 -> am_lock rises one cycle after block 16, am_strip pulses at the same time, bip_err_cnt stays 0.
- False start: markers at blocks 0 and 7, none at 16, a marker at 20, then every 16 blocks -> no lock at 16 (return to FIND_1ST), am_lock rises after block 36.
- Lock loss: after lock, drop 3 markers, then one good marker, then drop 4 -> lock held through the first 3 misses, invld_cnt reset by the good marker, am_lock falls after the 4th consecutive miss with no am_strip on it.
- BIP: locked lane, bip_valid=0 on two marker blocks -> two bip_err pulses, bip_err_cnt=2; bip_cnt_clr together with a third error -> count 0. With the macro undefined, bip_err_cnt=0 throughout.
- Stalls and block_lock: block_valid low for 5 cycles mid-period -> expected position delayed by 5 cycles, lock held. block_lock low for 1 cycle -> am_lock=0 next cycle, reacquisition needs two markers.
- Async reset asserted mid-LOCKED between clock edges -> all outputs 0 immediately, state LOCK_INIT after release.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 40GBASE-R PCS definitions: alignment-marker lock states, lane marker
// encodings and the default marker spacing used across the receive lanes.
package pcs_pkg;

   localparam int AM_SPACING_DEFAULT = 16384;
   localparam int PCS_LANES          = 4;
   localparam int AM_INVLD_CNT_W     = 4;

   typedef enum logic [1:0] {
      LOCK_INIT,
      FIND_1ST,
      COUNT_1,
      LOCKED
   } am_lock_state_t;

   // Marker bytes {M0, M1, M2} per PCS lane; M0 is the first byte on the wire.
   localparam logic [PCS_LANES-1:0][23:0] AM_LANE_PATTERN = {
      24'hA2_79_3D,
      24'hC5_65_9B,
      24'hF0_C4_E6,
      24'h90_76_47
   };

   // Marker block payload, byte 0 in the low bits: M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3.
   function automatic logic [63:0] am_payload(input logic [23:0] m, input logic [7:0] bip);
      return {~bip, ~m[7:0], ~m[15:8], ~m[23:16], bip, m[7:0], m[15:8], m[23:16]};
   endfunction

   // True when a received payload carries the marker of the given lane (BIP ignored).
   function automatic logic am_payload_match(input logic [63:0] payload, input int lane);
      logic [63:0] ref_pl;
      logic [63:0] mask;
      ref_pl = am_payload(AM_LANE_PATTERN[lane], 8'h00);
      mask   = 64'h00FF_FFFF_00FF_FFFF;
      return ((payload ^ ref_pl) & mask) == 64'd0;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating event counter with synchronous clear; clear wins over
// increment. Shared by the PCS error counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/alignment_lock.sv
// Per-lane alignment marker lock: tracks marker periodicity, flags locked
// marker positions for removal and reports BIP errors on them.
// ALIGN_LOCK_BIP_CNT_EN builds the saturating BIP error counter.
module alignment_lock
   import pcs_pkg::*;
#(
   parameter int AM_SPACING  = AM_SPACING_DEFAULT,
   parameter int INVLD_LIMIT = 4,
   parameter int BIP_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 block_valid,
   input  logic                 block_lock,
   input  logic                 marker_detect,
   input  logic                 bip_valid,
   input  logic                 bip_cnt_clr,
   output logic                 am_lock,
   output logic                 am_strip,
   output logic                 bip_err,
   output logic [BIP_CNT_W-1:0] bip_err_cnt
);

   localparam int                        CNT_W    = (AM_SPACING > 1) ? $clog2(AM_SPACING) : 1;
   localparam logic [CNT_W-1:0]          LAST_POS = CNT_W'(AM_SPACING - 1);
   localparam logic [AM_INVLD_CNT_W-1:0] LIMIT    = AM_INVLD_CNT_W'(INVLD_LIMIT);

   am_lock_state_t              state_q, state_d;
   logic [CNT_W-1:0]            blk_cnt_q, blk_cnt_d;
   logic [AM_INVLD_CNT_W-1:0]   invld_cnt_q, invld_cnt_d;
   logic                        am_lock_q, am_lock_d;
   logic                        am_strip_q, am_strip_d;
   logic                        bip_err_q, bip_err_d;
   logic                        exp_pos;
   logic                        last_miss;

   assign exp_pos   = block_valid && (blk_cnt_q == LAST_POS);
   assign last_miss = (invld_cnt_q + 1'b1) == LIMIT;

   always_comb begin
      state_d     = state_q;
      invld_cnt_d = invld_cnt_q;
      am_strip_d  = 1'b0;
      blk_cnt_d   = blk_cnt_q;

      // Free-running block position; wraps explicitly so odd spacings work.
      if (block_valid) begin
         blk_cnt_d = exp_pos ? '0 : blk_cnt_q + 1'b1;
      end

      unique case (state_q)
         LOCK_INIT: begin
            invld_cnt_d = '0;
            state_d     = FIND_1ST;
         end
         FIND_1ST: begin
            if (block_valid && marker_detect) begin
               blk_cnt_d = '0;
               state_d   = COUNT_1;
            end
         end
         COUNT_1: begin
            if (exp_pos) begin
               if (marker_detect) begin
                  state_d     = LOCKED;
                  invld_cnt_d = '0;
                  am_strip_d  = 1'b1;
               end else begin
                  state_d = FIND_1ST;
               end
            end
         end
         LOCKED: begin
            if (exp_pos) begin
               if (marker_detect) begin
                  invld_cnt_d = '0;
                  am_strip_d  = 1'b1;
               end else if (last_miss) begin
                  // The lock-dropping miss is not treated as a marker slot.
                  invld_cnt_d = '0;
                  state_d     = LOCK_INIT;
               end else begin
                  invld_cnt_d = invld_cnt_q + 1'b1;
                  am_strip_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = LOCK_INIT;
         end
      endcase

      if (!block_lock) begin
         state_d    = LOCK_INIT;
         am_strip_d = 1'b0;
      end

      am_lock_d = (state_d == LOCKED);
      bip_err_d = am_strip_d && marker_detect && !bip_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOCK_INIT;
         blk_cnt_q   <= '0;
         invld_cnt_q <= '0;
         am_lock_q   <= 1'b0;
         am_strip_q  <= 1'b0;
         bip_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_cnt_q   <= blk_cnt_d;
         invld_cnt_q <= invld_cnt_d;
         am_lock_q   <= am_lock_d;
         am_strip_q  <= am_strip_d;
         bip_err_q   <= bip_err_d;
      end
   end

   assign am_lock  = am_lock_q;
   assign am_strip = am_strip_q;
   assign bip_err  = bip_err_q;

`ifdef ALIGN_LOCK_BIP_CNT_EN
   // Counts on the same edge the bip_err pulse is registered.
   sat_counter #(
      .W(BIP_CNT_W)
   ) u_bip_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (bip_cnt_clr),
      .inc   (bip_err_d),
      .cnt   (bip_err_cnt)
   );
`else
   logic unused_bip_cnt_clr;
   assign unused_bip_cnt_clr = bip_cnt_clr;
   assign bip_err_cnt        = '0;
`endif

endmodule

// File: tb/tb_alignment_lock.sv
// Self-checking bench for alignment_lock: directed scenarios plus random
// traffic, compared cycle by cycle against a block-index based reference.
module tb_alignment_lock;

   localparam int SP   = 16;
   localparam int LIM  = 4;
   localparam int BW   = 3;
   localparam int CMAX = (1 << BW) - 1;
`ifdef ALIGN_LOCK_BIP_CNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          block_valid, block_lock, marker_detect, bip_valid, bip_cnt_clr;
   logic          am_lock, am_strip, bip_err;
   logic [BW-1:0] bip_err_cnt;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   alignment_lock #(
      .AM_SPACING  (SP),
      .INVLD_LIMIT (LIM),
      .BIP_CNT_W   (BW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .block_valid   (block_valid),
      .block_lock    (block_lock),
      .marker_detect (marker_detect),
      .bip_valid     (bip_valid),
      .bip_cnt_clr   (bip_cnt_clr),
      .am_lock       (am_lock),
      .am_strip      (am_strip),
      .bip_err       (bip_err),
      .bip_err_cnt   (bip_err_cnt)
   );

   // Reference: marker slots are absolute valid-block indices, anchor + k*SP.
   int     m_mode;      // 0 waiting for block lock, 1 searching, 2 confirming, 3 locked
   longint m_vidx, m_exp;
   int     m_miss;
   bit     e_lock, e_strip, e_err;
   int     e_cnt;

   task automatic model_reset();
      m_mode = 0; m_vidx = 0; m_exp = 0; m_miss = 0;
      e_lock = 0; e_strip = 0; e_err = 0; e_cnt = 0;
   endtask

   task automatic model_step();
      bit at_slot;
      bit strip;
      strip   = 0;
      at_slot = block_valid && (m_mode >= 2) && (m_vidx == m_exp);
      if (!block_lock) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: m_mode = 1;
            1: if (block_valid && marker_detect) begin
                  m_exp  = m_vidx + SP;
                  m_mode = 2;
               end
            2: if (at_slot) begin
                  if (marker_detect) begin
                     m_mode = 3; m_miss = 0; strip = 1; m_exp += SP;
                  end else begin
                     m_mode = 1;
                  end
               end
            default: if (at_slot) begin
                  m_exp += SP;
                  if (marker_detect) begin
                     m_miss = 0; strip = 1;
                  end else begin
                     m_miss++;
                     if (m_miss == LIM) m_mode = 0;
                     else strip = 1;
                  end
               end
         endcase
      end
      if (block_valid) m_vidx++;
      e_lock  = (m_mode == 3);
      e_strip = strip;
      e_err   = strip && marker_detect && !bip_valid;
      if (CNT_EN != 0) begin
         if (bip_cnt_clr) e_cnt = 0;
         else if (e_err && e_cnt < CMAX) e_cnt++;
      end
   endtask

   task automatic step(input bit v, input bit md, input bit bv, input bit bl, input bit clr);
      block_valid = v; marker_detect = md; bip_valid = bv; block_lock = bl; bip_cnt_clr = clr;
      model_step();
      @(posedge clk);
      #1;
      vectors++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      block_valid = 0; marker_detect = 0; bip_valid = 1; block_lock = 0; bip_cnt_clr = 0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic lead_in();
      do_reset();
      step(1, 0, 1, 1, 0);
      step(1, 0, 1, 1, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      block_valid = 1; marker_detect = 1; bip_valid = 0; block_lock = 1; bip_cnt_clr = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {3'b000, BW'(0)}) begin
         errors++;
         $display("FAIL reset got lock/strip/err/cnt=%b/%b/%b/%0d want 0/0/0/0", am_lock, am_strip, bip_err, bip_err_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_lock_acquire();
      lead_in();
      for (int i = 0; i <= 20; i++) begin
         step(1, (i == 0 || i == 16), 1, 1, 0);
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL acquire blk=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if ((i == 15 && am_lock !== 1'b0) || (i == 16 && {am_lock, am_strip} !== 2'b11) || bip_err_cnt !== BW'(0)) begin
            errors++;
            $display("FAIL acquire_edge blk=%0d got lock=%b strip=%b cnt=%0d want lock=%0d strip=%0d cnt=0", i, am_lock, am_strip, bip_err_cnt, i >= 16, i == 16);
         end
      end
   endtask

   task automatic test_false_start();
      lead_in();
      for (int i = 0; i <= 40; i++) begin
         step(1, (i == 0 || i == 7 || i == 20 || i == 36), 1, 1, 0);
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL false_start blk=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if ((i == 16 && {am_lock, am_strip} !== 2'b00) || (i == 35 && am_lock !== 1'b0) || (i == 36 && am_lock !== 1'b1)) begin
            errors++;
            $display("FAIL false_start_edge blk=%0d got lock=%b strip=%b want lock=%0d", i, am_lock, am_strip, i >= 36);
         end
      end
   endtask

   task automatic test_lock_loss();
      bit md;
      lead_in();
      for (int i = 0; i <= 150; i++) begin
         md = (i % SP == 0) && !(i == 32 || i == 48 || i == 64 || i == 96 || i == 112 || i == 128 || i == 144);
         step(1, md, 1, 1, 0);
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL lock_loss blk=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if (((i == 64 || i == 80 || i == 128) && {am_lock, am_strip} !== 2'b11) || (i == 144 && {am_lock, am_strip} !== 2'b00)) begin
            errors++;
            $display("FAIL lock_loss_edge blk=%0d got lock=%b strip=%b want both=%0d", i, am_lock, am_strip, i != 144);
         end
      end
   endtask

   task automatic test_bip();
      bit bv;
      lead_in();
      for (int i = 0; i <= 64 + 9 * SP; i++) begin
         bv = !(i == 32 || i == 48 || i >= 64);
         step(1, (i % SP == 0), bv, 1, (i == 64));
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL bip blk=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if ((i == 32 && bip_err !== 1'b1) || (i == 48 && bip_err_cnt !== BW'(2 * CNT_EN)) || (i == 64 && bip_err_cnt !== BW'(0)) ||
             (i == 64 + 9 * SP && bip_err_cnt !== BW'(CMAX * CNT_EN))) begin
            errors++;
            $display("FAIL bip_count blk=%0d got err=%b cnt=%0d", i, bip_err, bip_err_cnt);
         end
      end
   endtask

   task automatic test_stall();
      int  vi;
      bit  v;
      lead_in();
      vi = 0;
      for (int c = 0; c < 45; c++) begin
         v = !(c >= 21 && c < 26);
         step(v, v ? (vi % SP == 0) : 1'b1, 1, 1, 0);
         if (v) vi++;
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL stall cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if ((c == 32 && {am_lock, am_strip} !== 2'b10) || (c == 37 && {am_lock, am_strip} !== 2'b11)) begin
            errors++;
            $display("FAIL stall_edge cyc=%0d got lock=%b strip=%b want strip=%0d", c, am_lock, am_strip, c == 37);
         end
      end
   endtask

   task automatic test_block_lock_drop();
      lead_in();
      for (int i = 0; i <= 60; i++) begin
         step(1, (i % SP == 0), 1, (i != 20), 0);
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL block_lock blk=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if ((i == 19 && am_lock !== 1'b1) || (i == 20 && am_lock !== 1'b0) || (i == 32 && am_lock !== 1'b0) || (i == 48 && am_lock !== 1'b1)) begin
            errors++;
            $display("FAIL block_lock_edge blk=%0d got lock=%b", i, am_lock);
         end
      end
   endtask

   task automatic test_async_reset();
      lead_in();
      for (int i = 0; i <= 20; i++) begin
         step(1, (i % SP == 0), (i != 16), 1, 0);
      end
      if ({am_lock, bip_err_cnt} !== {1'b1, BW'(CNT_EN)}) begin
         errors++;
         $display("FAIL async_pre got lock=%b cnt=%0d want 1/%0d", am_lock, bip_err_cnt, CNT_EN);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {3'b000, BW'(0)}) begin
         errors++;
         $display("FAIL async_reset got %b/%b/%b/%0d want 0/0/0/0", am_lock, am_strip, bip_err, bip_err_cnt);
      end
      model_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      for (int i = 21; i <= 50; i++) begin
         step(1, (i % SP == 0), 1, 1, 0);
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL async_relock blk=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
         if ((i == 32 && am_lock !== 1'b0) || (i == 48 && am_lock !== 1'b1)) begin
            errors++;
            $display("FAIL async_relock_edge blk=%0d got lock=%b", i, am_lock);
         end
      end
   endtask

   task automatic test_random();
      int vi;
      bit v, md, bl;
      do_reset();
      vi = 0;
      for (int c = 0; c < 3000; c++) begin
         v  = ($urandom % 10) != 0;
         bl = ($urandom % 400) != 0;
         md = v ? (((vi % SP) == 5 && ($urandom % 8) != 0) || ($urandom % 40) == 0) : 1'($urandom % 2);
         step(v, md, ($urandom % 5) != 0, bl, ($urandom % 50) == 0);
         if (v) vi++;
         if ({am_lock, am_strip, bip_err, bip_err_cnt} !== {e_lock, e_strip, e_err, BW'(e_cnt)}) begin
            errors++;
            $display("FAIL random cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c, am_lock, am_strip, bip_err, bip_err_cnt, e_lock, e_strip, e_err, e_cnt);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      block_valid = 0; marker_detect = 0; bip_valid = 1; block_lock = 0; bip_cnt_clr = 0;
      test_reset();
      test_lock_acquire();
      test_false_start();
      test_lock_loss();
      test_bip();
      test_stall();
      test_block_lock_drop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
